altpcierd_cdma_ast_msi_arb: RTL
===============================

Name: altpcierd_cdma_ast_msi_arb

Overview:
- Multi-channel MSI request arbiter and Avalon-ST MSI beat generator for the chaining DMA application.
- Accepts level-style MSI requests (req/ack) from NUM_CH independent sources, such as the read DMA, the write DMA and user logic.
- Captures each request's traffic class and vector on the rising edge of the request, then arbitrates round-robin.
- Emits one 8-bit MSI beat per grant on the stream port, paced by a registered ready and an optional inter-MSI gap.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- GAP_CYCLES, 0, minimum idle cycles after each issued beat before the next grant (0..255).
- CNT_W, 16, width of the sent and dropped statistics counters.

Ports:
- clk_in  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- app_msi_req  input  NUM_CH  per-channel request level; channel i is bit i.
- app_msi_ack  output  NUM_CH  per-channel one-cycle ack pulse.
- app_msi_tc  input  3*NUM_CH  per-channel traffic class; channel i is bits [3i+2:3i].
- app_msi_num  input  5*NUM_CH  per-channel MSI vector; channel i is bits [5i+4:5i].
- stream_ready  input  1  sink ready.
- stream_data  output  8  MSI beat: [7:5]=tc, [4:0]=num.
- stream_valid  output  1  beat valid, one cycle per MSI.
- msi_sent_cnt  output  CNT_W  total beats issued; wraps at 2^CNT_W.
- msi_drop_cnt  output  CNT_W  request edges lost to an occupied pending slot; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): all outputs 0 (app_msi_ack, stream_valid, stream_data, both counters). All internal state cleared: ready_q, req_r, pend, hold regs, gap counter, last_grant=NUM_CH-1, state=IDLE. A request edge in flight when reset asserts is lost. After reset release, a req already high is seen as an edge, because req_r was reset to 0.
- Input register: ready_q <= stream_ready every cycle. Only ready_q is used for issue decisions, giving an effective ready latency of 1 cycle.
- Edge capture, per channel i:
  - edge_i = app_msi_req[i] & ~req_r[i]; req_r[i] <= app_msi_req[i].
  - On edge_i with pend[i]=0: pend[i] <= 1; hold_tc[i], hold_num[i] <= inputs sampled that cycle.
  - On edge_i with pend[i]=1 and channel i not granted this cycle: edge dropped, hold regs unchanged, msi_drop_cnt += 1 (saturating). Multiple channels dropping in the same cycle add their count in one step, saturating.
  - On edge_i in the same cycle that channel i is granted: the grant clears the old entry; the new edge sets pend[i] again and reloads the hold regs. Set wins; no drop is counted.
- State machine:
  - IDLE: if ready_q=1 and |pend, grant the first pending channel searching from last_grant+1 upward, modulo NUM_CH. In that cycle, registered so visible on the next edge:
    - stream_valid <= 1;
    - stream_data <= {hold_tc[g], hold_num[g]};
    - app_msi_ack[g] <= 1;
    - pend[g] <= 0 (unless set-wins applies);
    - last_grant <= g;
    - msi_sent_cnt += 1.
    Then go to GAP if GAP_CYCLES>0 (gap_cnt <= GAP_CYCLES), otherwise stay in IDLE, so a beat can issue every cycle.
  - IDLE with ready_q=0 or no pend: no beat; outputs valid/ack return to 0.
  - GAP: gap_cnt decrements each cycle. When gap_cnt==1, return to IDLE. Edge capture continues during GAP; no grants occur.
- stream_valid and app_msi_ack are single-cycle pulses. stream_data holds its last value when not valid.
- Latency: req rising at edge N → pend set at N+1 → beat and ack at N+2, given ready_q=1 and no contention.
- Requesters must hold tc/num stable only in the edge cycle. The req level may stay high after ack; a new MSI requires req to fall and rise again.
- No deassertion of stream_valid on ready drop mid-beat: a beat is issued only when ready_q=1, and the sink guarantees it accepts beats issued under ready latency 1.

Test Plan:
- Single channel, NUM_CH=2, GAP=0, ready=1: ch0 req rises at cycle 10 with tc=3, num=5 → stream_valid=1 and stream_data=8'h65 at cycle 12; app_msi_ack[0] pulses at cycle 12; msi_sent_cnt=1.
- Round-robin: ch0 and ch1 req rise in the same cycle (tc/num 0/1 and 0/2), last_grant=1 → beats 8'h01 then 8'h02 on consecutive cycles; next simultaneous pair → 8'h01 first again.
- Backpressure: stream_ready=0 while ch1 is pending, then raised at cycle 20 → no valid before cycle 22; beat at cycle 22; pend held throughout.
- Gap, GAP_CYCLES=3: three channels pending, NUM_CH=4 → valid pulses exactly 4 cycles apart.
- Drop and set-wins: ch0 edge while pend[0]=1 and ready=0 → msi_drop_cnt=1, original tc/num issued. Edge in the grant cycle → two beats, drop count unchanged.
- Reset mid-operation: assert rst with 2 pending and a beat in flight → all outputs 0 immediately. After release with ch0 req still high → one beat issued 2 cycles later.

Source files
------------

// File: rtl/altpcierd_cdma_ast_msi_arb.sv
// Multi-channel MSI arbiter for the chaining DMA application.
// Each request's tc/vector is captured on its rising edge into a per-channel
// pending slot. Pending slots are granted round-robin, one 8-bit MSI beat per
// grant. A registered ready and an optional inter-MSI gap pace the beats.
module altpcierd_cdma_ast_msi_arb #(
    parameter int NUM_CH     = 2,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     app_msi_req,
    output logic [NUM_CH-1:0]     app_msi_ack,
    input  logic [3*NUM_CH-1:0]   app_msi_tc,
    input  logic [5*NUM_CH-1:0]   app_msi_num,
    input  logic                  stream_ready,
    output logic [7:0]            stream_data,
    output logic                  stream_valid,
    output logic [CNT_W-1:0]      msi_sent_cnt,
    output logic [CNT_W-1:0]      msi_drop_cnt
);

    localparam int              IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]      GAP_INIT = 8'(GAP_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [7:0]            gap_cnt, gap_next;
    logic                  ready_q;
    logic [NUM_CH-1:0]     req_r;
    logic [NUM_CH-1:0]     pend;
    logic [3*NUM_CH-1:0]   hold_tc;
    logic [5*NUM_CH-1:0]   hold_num;
    logic [IDX_W-1:0]      last_grant;

    logic [NUM_CH-1:0]     edge_det;
    logic [NUM_CH-1:0]     grant_oh;
    logic [NUM_CH-1:0]     load;
    logic [NUM_CH-1:0]     drop_vec;
    logic                  grant_found;
    logic                  grant_en;
    logic [IDX_W-1:0]      grant_idx;
    logic [7:0]            sel_data;
    logic [3:0]            drop_num;
    logic [CNT_W+3:0]      drop_sum;
    logic [CNT_W-1:0]      drop_next;

    assign edge_det = app_msi_req & ~req_r;
    assign grant_en = (state == ST_IDLE) && ready_q && grant_found;
    // A grant in the same cycle as a new edge frees the slot, so the edge loads it.
    assign load     = edge_det & (~pend | grant_oh);
    assign drop_vec = edge_det & pend & ~grant_oh;

    // Round-robin pick: first pending channel above last_grant, then wrap to 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        sel_data    = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && pend[i] && (i > int'(last_grant))) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
                sel_data    = {hold_tc[3*i +: 3], hold_num[5*i +: 5]};
            end else begin
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && pend[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
                sel_data    = {hold_tc[3*i +: 3], hold_num[5*i +: 5]};
            end else begin
            end
        end
    end

    // One-hot grant vector, all zero when no beat issues this cycle.
    always_comb begin
        grant_oh = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            grant_oh[i] = grant_en && (grant_idx == IDX_W'(i));
        end
    end

    // Count dropped edges this cycle and form the saturated drop counter value.
    always_comb begin
        drop_num = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_num = drop_num + {3'b000, drop_vec[i]};
        end
        drop_sum = {4'b0000, msi_drop_cnt} + {{CNT_W{1'b0}}, drop_num};
        if (|drop_sum[CNT_W+3:CNT_W]) begin
            drop_next = {CNT_W{1'b1}};
        end else begin
            drop_next = drop_sum[CNT_W-1:0];
        end
    end

    // Next-state logic: a grant opens a gap window when GAP_CYCLES is nonzero.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (grant_en && (GAP_CYCLES > 0)) begin
                    state_next = ST_GAP;
                    gap_next   = GAP_INIT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_next = gap_cnt - 8'd1;
                if (gap_cnt <= 8'd1) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_GAP;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gap_next   = 8'd0;
            end
        endcase
    end

    // State and gap counter registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            gap_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
        end
    end

    // Input registering, edge history, pending slots and captured tc/vector.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            req_r    <= {NUM_CH{1'b0}};
            pend     <= {NUM_CH{1'b0}};
            hold_tc  <= {(3*NUM_CH){1'b0}};
            hold_num <= {(5*NUM_CH){1'b0}};
        end else begin
            ready_q <= stream_ready;
            req_r   <= app_msi_req;
            pend    <= (pend & ~grant_oh) | load;
            for (int i = 0; i < NUM_CH; i++) begin
                if (load[i]) begin
                    hold_tc[3*i +: 3]  <= app_msi_tc[3*i +: 3];
                    hold_num[5*i +: 5] <= app_msi_num[5*i +: 5];
                end else begin
                    hold_tc[3*i +: 3]  <= hold_tc[3*i +: 3];
                    hold_num[5*i +: 5] <= hold_num[5*i +: 5];
                end
            end
        end
    end

    // Registered beat, ack pulse, round-robin pointer and statistics.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stream_valid <= 1'b0;
            stream_data  <= 8'h00;
            app_msi_ack  <= {NUM_CH{1'b0}};
            last_grant   <= LAST_CH;
            msi_sent_cnt <= {CNT_W{1'b0}};
            msi_drop_cnt <= {CNT_W{1'b0}};
        end else begin
            msi_drop_cnt <= drop_next;
            if (grant_en) begin
                stream_valid <= 1'b1;
                stream_data  <= sel_data;
                app_msi_ack  <= grant_oh;
                last_grant   <= grant_idx;
                msi_sent_cnt <= msi_sent_cnt + CNT_W'(1);
            end else begin
                stream_valid <= 1'b0;
                app_msi_ack  <= {NUM_CH{1'b0}};
            end
        end
    end

endmodule
